mem_port_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single-cycle core's shared load/store port. Requester 0 is the core's load/store path; requester 1 is the debug/program loader. The block serialises their accesses onto the one LSU memory port and tracks read latency. For each read it returns the data, with a valid strobe, to the requester that issued it.

---
 rtl/mem_arb_pkg.sv | 7 +
 rtl/mem_port_arbiter_if.sv | 33 +++
 rtl/arb_pick.sv | 25 ++
 rtl/mem_port_arbiter.sv | 112 +++++++++++
 tb/tb_mem_port_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state, id types and read-latency limits for mem_port_arbiter.
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_e;
    typedef logic req_id_t;
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 3;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester and LSU-side signals of the arbiter; slave = arbiter, master = requesters/LSU.
interface mem_port_arbiter_if #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEMOP_W = 3
);
    logic               r0_req_i, r1_req_i;
    logic               r0_wren_i, r1_wren_i;
    logic [ADDR_W-1:0]  r0_addr_i, r1_addr_i;
    logic [DATA_W-1:0]  r0_wdata_i, r1_wdata_i;
    logic [MEMOP_W-1:0] r0_mem_op_i, r1_mem_op_i;
    logic               r0_gnt_o, r1_gnt_o;
    logic               r0_rvalid_o, r1_rvalid_o;
    logic [DATA_W-1:0]  r0_rdata_o, r1_rdata_o;
    logic               m_req_o, m_wren_o;
    logic [ADDR_W-1:0]  m_addr_o;
    logic [DATA_W-1:0]  m_wdata_o;
    logic [MEMOP_W-1:0] m_mem_op_o;
    logic [DATA_W-1:0]  m_rdata_i;

    modport slave (
        input  r0_req_i, r1_req_i, r0_wren_i, r1_wren_i, r0_addr_i, r1_addr_i,
               r0_wdata_i, r1_wdata_i, r0_mem_op_i, r1_mem_op_i, m_rdata_i,
        output r0_gnt_o, r1_gnt_o, r0_rvalid_o, r1_rvalid_o, r0_rdata_o, r1_rdata_o,
               m_req_o, m_wren_o, m_addr_o, m_wdata_o, m_mem_op_o
    );
    modport master (
        output r0_req_i, r1_req_i, r0_wren_i, r1_wren_i, r0_addr_i, r1_addr_i,
               r0_wdata_i, r1_wdata_i, r0_mem_op_i, r1_mem_op_i, m_rdata_i,
        input  r0_gnt_o, r1_gnt_o, r0_rvalid_o, r1_rvalid_o, r0_rdata_o, r1_rdata_o,
               m_req_o, m_wren_o, m_addr_o, m_wdata_o, m_mem_op_o
    );
endinterface

// File: rtl/arb_pick.sv
// arb_pick: two-way winner select; MEM_ARB_RR_EN builds a last-grant pointer for round-robin ties,
// otherwise requester 0 always wins a tie.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic    clk_i,
    input  logic    rst_ni,
    input  logic    req0_i,
    input  logic    req1_i,
    input  logic    upd_i,
    output req_id_t win_o
);
`ifdef MEM_ARB_RR_EN
    req_id_t last_q;
    assign win_o = (req0_i && req1_i) ? ~last_q : req_id_t'(!req0_i);
    // Reset to 1 so requester 0 takes the first tie.
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) last_q <= req_id_t'(1'b1);
        else if (upd_i) last_q <= win_o;
`else
    logic unused;
    assign unused = ^{clk_i, rst_ni, upd_i, req1_i};
    assign win_o = req_id_t'(!req0_i);
`endif
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises two requesters onto the single LSU port and returns load data to the issuer.
// Define MEM_ARB_RR_EN for round-robin tie-breaking (default: fixed priority, requester 0).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEMOP_W = 3,
    parameter int RD_LAT  = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    mem_port_arbiter_if.slave bus,
    output logic              busy_o
);
    localparam int LAT = RD_LAT < RD_LAT_MIN ? RD_LAT_MIN : RD_LAT > RD_LAT_MAX ? RD_LAT_MAX : RD_LAT;

    arb_state_e         state_q, state_d;
    req_id_t            id_q, id_d, win;
    logic [1:0]         cnt_q, cnt_d;
    logic               m_wren_q, m_wren_d;
    logic [ADDR_W-1:0]  m_addr_q, m_addr_d;
    logic [DATA_W-1:0]  m_wdata_q, m_wdata_d;
    logic [MEMOP_W-1:0] m_op_q, m_op_d;
    logic [DATA_W-1:0]  rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic               start, cap;

    assign start = state_q == IDLE && (bus.r0_req_i || bus.r1_req_i);

    arb_pick u_pick (
        .clk_i,
        .rst_ni,
        .req0_i(bus.r0_req_i),
        .req1_i(bus.r1_req_i),
        .upd_i (start),
        .win_o (win)
    );

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        cnt_d     = cnt_q;
        m_wren_d  = m_wren_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        m_op_d    = m_op_q;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        cap       = 1'b0;
        unique case (state_q)
            IDLE: if (start) begin
                state_d   = ISSUE;
                id_d      = win;
                m_wren_d  = win ? bus.r1_wren_i : bus.r0_wren_i;
                m_addr_d  = win ? bus.r1_addr_i : bus.r0_addr_i;
                m_wdata_d = win ? bus.r1_wdata_i : bus.r0_wdata_i;
                m_op_d    = win ? bus.r1_mem_op_i : bus.r0_mem_op_i;
            end
            ISSUE: begin
                cnt_d   = 2'(LAT - 1);
                cap     = !m_wren_q && LAT == 1;
                state_d = m_wren_q ? IDLE : (LAT > 1 ? WAIT : RESP);
            end
            // The cycle whose count would reach zero is the one the LSU data is valid in.
            WAIT: begin
                cnt_d   = cnt_q - 2'd1;
                cap     = cnt_q == 2'd1;
                state_d = cap ? RESP : WAIT;
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (cap && !id_q) rdata0_d = bus.m_rdata_i;
        if (cap && id_q) rdata1_d = bus.m_rdata_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            state_q   <= IDLE;
            id_q      <= '0;
            cnt_q     <= '0;
            m_wren_q  <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_op_q    <= '0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            cnt_q     <= cnt_d;
            m_wren_q  <= m_wren_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            m_op_q    <= m_op_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end

    assign bus.m_req_o     = state_q == ISSUE;
    assign bus.r0_gnt_o    = state_q == ISSUE && !id_q;
    assign bus.r1_gnt_o    = state_q == ISSUE && id_q;
    assign bus.r0_rvalid_o = state_q == RESP && !id_q;
    assign bus.r1_rvalid_o = state_q == RESP && id_q;
    assign bus.r0_rdata_o  = rdata0_q;
    assign bus.r1_rdata_o  = rdata1_q;
    assign bus.m_wren_o    = m_wren_q;
    assign bus.m_addr_o    = m_addr_q;
    assign bus.m_wdata_o   = m_wdata_q;
    assign bus.m_mem_op_o  = m_op_q;
    assign busy_o          = state_q != IDLE;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized scoreboard bench; a transaction-timeline model predicts grants,
// LSU commands, busy and returned load data for mem_port_arbiter.
module tb_mem_port_arbiter;
    localparam int RD_LAT = 2;

    typedef struct { logic w; logic [31:0] a; logic [31:0] d; logic [2:0] o; } cmd_t;
    typedef struct { int c; int id; cmd_t cmd; } gexp_t;
    typedef struct { int c; int id; int s; } rexp_t;

    logic clk = 0;
    logic rst_ni = 0;
    logic busy;
    logic rq [2];
    logic wd [2];
    logic wren [2];
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic [2:0] op [2];
    cmd_t cq0[$];
    cmd_t cq1[$];
    gexp_t eg[$];
    rexp_t er[$];
    int glog[$];
    logic [31:0] rd_hist [int];
    logic [31:0] rdl [2];
    cmd_t mlast;
    int cyc = 0, free_at = 0, act_s = 0, act_e = 0, last = 1;
    int checks = 0, errors = 0;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32), .MEMOP_W(3)) bus ();

    assign bus.r0_req_i    = rq[0];
    assign bus.r1_req_i    = rq[1];
    assign bus.r0_wren_i   = wren[0];
    assign bus.r1_wren_i   = wren[1];
    assign bus.r0_addr_i   = addr[0];
    assign bus.r1_addr_i   = addr[1];
    assign bus.r0_wdata_i  = wdata[0];
    assign bus.r1_wdata_i  = wdata[1];
    assign bus.r0_mem_op_i = op[0];
    assign bus.r1_mem_op_i = op[1];

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEMOP_W(3), .RD_LAT(RD_LAT)) dut (
        .clk_i (clk),
        .rst_ni(rst_ni),
        .bus   (bus),
        .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(string n, logic [63:0] a, logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, want %0h", n, cyc, a, e);
        end
    endtask

    function automatic int qsz(int i);
        return i == 0 ? cq0.size() : cq1.size();
    endfunction

    task automatic push(int i, cmd_t c);
        if (i == 0) cq0.push_back(c);
        else cq1.push_back(c);
    endtask

    function automatic cmd_t rnd_cmd();
        cmd_t c;
        c.w = 1'($urandom_range(1));
        c.a = $urandom;
        c.d = $urandom;
        c.o = 3'($urandom_range(7));
        return c;
    endfunction

    task automatic drive(int i);
        cmd_t c;
        if (i == 0) c = cq0.pop_front();
        else c = cq1.pop_front();
        rq[i] = 1;
        wren[i] = c.w;
        addr[i] = c.a;
        wdata[i] = c.d;
        op[i] = c.o;
    endtask

    // Requester drivers and LSU read-data source: act on the falling edge.
    always @(negedge clk) begin
        logic g [2];
        g[0] = bus.r0_gnt_o;
        g[1] = bus.r1_gnt_o;
        bus.m_rdata_i = $urandom;
        rd_hist[cyc] = bus.m_rdata_i;
        for (int i = 0; i < 2; i++) begin
            if (!rst_ni) begin
                rq[i] = 0;
                wd[i] = 0;
            end else if (rq[i] && g[i]) begin
                wd[i] = 0;
                if (qsz(i) > 0) drive(i);
                else rq[i] = 0;
            end else if (rq[i] && wd[i]) begin
                rq[i] = 0;
                wd[i] = 0;
            end else if (!rq[i] && qsz(i) > 0) drive(i);
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: the port is free again 2 cycles after a store's arbitration edge and
    // RD_LAT+2 after a load's; data is whatever the LSU drove RD_LAT-1 cycles after ISSUE.
    always @(posedge clk or negedge rst_ni) begin
        int k, w;
        cmd_t cm;
        if (!rst_ni) begin
            eg.delete();
            er.delete();
            free_at = 0;
            act_s = 0;
            act_e = 0;
            last = 1;
            rdl[0] = 0;
            rdl[1] = 0;
            mlast = '{1'b0, 32'h0, 32'h0, 3'h0};
        end else begin
            k = cyc + 1;
            if (k >= free_at && (rq[0] || rq[1])) begin
`ifdef MEM_ARB_RR_EN
                w = (rq[0] && rq[1]) ? 1 - last : (rq[0] ? 0 : 1);
                last = w;
`else
                w = rq[0] ? 0 : 1;
`endif
                cm = '{wren[w], addr[w], wdata[w], op[w]};
                eg.push_back('{k, w, cm});
                if (cm.w) free_at = k + 2;
                else begin
                    er.push_back('{k + RD_LAT, w, k + RD_LAT - 1});
                    free_at = k + RD_LAT + 2;
                end
                act_s = k;
                act_e = free_at - 1;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a grant or a load response.
    always @(negedge clk) if (rst_ni) begin
        logic g0, g1, v0, v1;
        gexp_t e;
        rexp_t r;
        g0 = bus.r0_gnt_o;
        g1 = bus.r1_gnt_o;
        v0 = bus.r0_rvalid_o;
        v1 = bus.r1_rvalid_o;
        chk("busy", busy, cyc >= act_s && cyc < act_e);
        if (g0 || g1 || bus.m_req_o) begin
            if (eg.size() == 0) chk("unexpected_gnt", {bus.m_req_o, g1, g0}, 0);
            else begin
                e = eg.pop_front();
                chk("gnt_cycle", cyc, e.c);
                chk("gnt_id", {bus.m_req_o, g1, g0}, e.id != 0 ? 3'b110 : 3'b101);
                chk("m_addr", bus.m_addr_o, e.cmd.a);
                chk("m_wdata", bus.m_wdata_o, e.cmd.d);
                chk("m_wren_op", {bus.m_wren_o, bus.m_mem_op_o}, {e.cmd.w, e.cmd.o});
                mlast = e.cmd;
                glog.push_back(e.id);
            end
        end else begin
            if (eg.size() > 0 && eg[0].c <= cyc) begin
                chk("missed_gnt", 0, 1);
                e = eg.pop_front();
            end
            chk("m_hold", {bus.m_wren_o, bus.m_mem_op_o, bus.m_addr_o}, {mlast.w, mlast.o, mlast.a});
            chk("m_hold_wdata", bus.m_wdata_o, mlast.d);
        end
        if (v0 || v1) begin
            if (er.size() == 0) chk("unexpected_rvalid", {v1, v0}, 0);
            else begin
                r = er.pop_front();
                chk("rvalid_cycle", cyc, r.c);
                chk("rvalid_id", {v1, v0}, r.id != 0 ? 2'b10 : 2'b01);
                rdl[r.id] = rd_hist[r.s];
            end
        end else if (er.size() > 0 && er[0].c <= cyc) begin
            chk("missed_rvalid", 0, 1);
            r = er.pop_front();
        end
        chk("r0_rdata", bus.r0_rdata_o, rdl[0]);
        chk("r1_rdata", bus.r1_rdata_o, rdl[1]);
    end

    task automatic chk_reset(string n);
        chk({n, "_ctl"}, {bus.r0_gnt_o, bus.r1_gnt_o, bus.r0_rvalid_o, bus.r1_rvalid_o,
                          bus.m_req_o, bus.m_wren_o, busy, bus.m_mem_op_o}, 0);
        chk({n, "_addr"}, bus.m_addr_o, 0);
        chk({n, "_wdata"}, bus.m_wdata_o, 0);
        chk({n, "_rdata0"}, bus.r0_rdata_o, 0);
        chk({n, "_rdata1"}, bus.r1_rdata_o, 0);
    endtask

    task automatic drain(int n);
        int t = 0;
        while ((qsz(0) > 0 || qsz(1) > 0 || rq[0] || rq[1] || eg.size() > 0 || er.size() > 0) && t < n) begin
            @(posedge clk);
            t++;
        end
        chk("drain_timeout", t >= n, 0);
        repeat (2) @(posedge clk);
        #2;
    endtask

    task automatic wait_gnt(int i);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(i != 0 ? bus.r1_gnt_o : bus.r0_gnt_o) && t < 20);
        chk("gnt_wait_timeout", t >= 20, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "bench did not finish");
    end

    initial begin
        cmd_t c;
        for (int i = 0; i < 2; i++) begin
            rq[i] = 0;
            wd[i] = 0;
            wren[i] = 0;
            addr[i] = 0;
            wdata[i] = 0;
            op[i] = 0;
        end
        bus.m_rdata_i = 0;
        repeat (3) @(posedge clk);
        #1 chk_reset("reset_init");
        #1 rst_ni = 1;

        @(posedge clk);
        #2;
        glog.delete();
        for (int n = 0; n < 4; n++) begin
            push(0, rnd_cmd());
            push(1, rnd_cmd());
        end
        drain(400);
        chk("contention_count", glog.size(), 8);
        for (int n = 0; n < glog.size() && n < 8; n++) begin
`ifdef MEM_ARB_RR_EN
            chk("rr_order", glog[n], n % 2);
`else
            chk("fixed_order", glog[n], n / 4);
`endif
        end

        c = '{1'b1, 32'h0000_7000, 32'hDEAD_BEEF, 3'd2};
        push(0, c);
        drain(50);
        chk("store_busy_after", busy, 0);

        c = '{1'b0, 32'h0000_0100, 32'h0, 3'd2};
        push(1, c);
        drain(50);

        c = '{1'b0, 32'h0000_0200, 32'h0, 3'd1};
        push(0, c);
        wait_gnt(0);
        @(posedge clk);
        #2;
        c = '{1'b1, 32'h0000_0300, 32'hCAFE_F00D, 3'd0};
        push(1, c);
        drain(50);

        c = '{1'b0, 32'h0000_0400, 32'h0, 3'd2};
        push(0, c);
        wait_gnt(0);
        @(posedge clk);
        #2 rst_ni = 0;
        #1 chk_reset("reset_wait");
        repeat (2) @(posedge clk);
        #2 rst_ni = 1;
        c = '{1'b0, 32'h0000_0500, 32'h0, 3'd4};
        push(1, c);
        drain(50);

        for (int n = 0; n < 400; n++) begin
            @(posedge clk);
            #2;
            for (int i = 0; i < 2; i++) begin
                if (qsz(i) < 2 && $urandom_range(3) == 0) push(i, rnd_cmd());
                if ($urandom_range(15) == 0) wd[i] = 1;
            end
        end
        drain(600);

        chk("leftover_gnt", eg.size(), 0);
        chk("leftover_rvalid", er.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
